// File: rtl/data_mem_master.sv
// Load/store master for a word-wide data memory: byte-lane steering, split
// (misaligned) accesses over two words, sign/zero extension and range checking.
module data_mem_master #(
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [2:0]        req_func3,
    input  logic [31:0]       req_addr,
    input  logic [31:0]       req_wdata,
    output logic              resp_valid,
    output logic [31:0]       resp_rdata,
    output logic              resp_err,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_re,
    output logic              mem_we,
    output logic [3:0]        mem_be,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata
);

    typedef enum logic [1:0] {IDLE, ACC0, ACC1, DONE} state_t;

    state_t state, state_nxt;

    logic              write_q, err_q, split_q;
    logic [2:0]        func3_q;
    logic [1:0]        off_q;
    logic [ADDR_W-1:0] word_q;
    logic [31:0]       wdata_q, word0_q;

    logic [2:0]  req_size;
    logic [32:0] last_byte;
    logic        req_err, req_split;
    logic [3:0]  size_mask;
    logic [7:0]  be_pair;
    logic [63:0] wdata_pair;

    function automatic logic [2:0] size_of(input logic [1:0] code);
        case (code)
            2'b00:   return 3'd1;
            2'b01:   return 3'd2;
            default: return 3'd4;
        endcase
    endfunction

    // Selects the addressed bytes from the two-word window and extends them.
    function automatic logic [31:0] load_extend(input logic [63:0] pair,
                                                input logic [1:0]  off,
                                                input logic [2:0]  f3);
        logic [31:0]        sh;
        logic signed [31:0] ext;
        sh = 32'(pair >> {off, 3'b000});
        case (f3)
            3'b000:  ext = $signed({sh[7:0], 24'h0}) >>> 24;
            3'b001:  ext = $signed({sh[15:0], 16'h0}) >>> 16;
            3'b100:  ext = {24'h0, sh[7:0]};
            3'b101:  ext = {16'h0, sh[15:0]};
            default: ext = sh;
        endcase
        return ext;
    endfunction

    always_comb begin
        req_size  = size_of(req_func3[1:0]);
        last_byte = {1'b0, req_addr} + {30'h0, req_size} - 33'd1;
        req_err   = (req_func3 == 3'b011) || (req_func3[2:1] == 2'b11)
                    || (req_write && req_func3[2])
                    || (|last_byte[32:ADDR_W+2]);
        req_split = ((req_func3[1:0] == 2'b01) && (req_addr[1:0] == 2'b11))
                    || ((req_func3[1:0] == 2'b10) && (req_addr[1:0] != 2'b00));
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Request fields and the first read word carry no reset: only meaningful once accepted.
    always_ff @(posedge clk) begin
        if (state == IDLE && req_valid) begin
            write_q <= req_write;
            func3_q <= req_func3;
            off_q   <= req_addr[1:0];
            word_q  <= req_addr[ADDR_W+1:2];
            wdata_q <= req_wdata;
            err_q   <= req_err;
            split_q <= req_split;
        end
        if (state == ACC1) begin
            word0_q <= mem_rdata;
        end
    end

    // Lane masks and data shifted across a 2-word window; the low half goes out in ACC0.
    always_comb begin
        case (func3_q[1:0])
            2'b00:   size_mask = 4'b0001;
            2'b01:   size_mask = 4'b0011;
            default: size_mask = 4'b1111;
        endcase
        be_pair    = {4'h0, size_mask} << off_q;
        wdata_pair = {32'h0, wdata_q} << {off_q, 3'b000};
    end

    always_comb begin
        state_nxt  = state;
        req_ready  = 1'b0;
        resp_valid = 1'b0;
        resp_err   = 1'b0;
        resp_rdata = 32'h0;
        mem_addr   = '0;
        mem_re     = 1'b0;
        mem_we     = 1'b0;
        mem_be     = 4'h0;
        mem_wdata  = 32'h0;
        case (state)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    state_nxt = req_err ? DONE : ACC0;
                end
            end
            ACC0: begin
                mem_addr  = word_q;
                mem_be    = be_pair[3:0];
                mem_re    = !write_q;
                mem_we    = write_q;
                mem_wdata = write_q ? wdata_pair[31:0] : 32'h0;
                state_nxt = split_q ? ACC1 : DONE;
            end
            ACC1: begin
                mem_addr  = word_q + ADDR_W'(1);
                mem_be    = be_pair[7:4];
                mem_re    = !write_q;
                mem_we    = write_q;
                mem_wdata = write_q ? wdata_pair[63:32] : 32'h0;
                state_nxt = DONE;
            end
            DONE: begin
                resp_valid = 1'b1;
                resp_err   = err_q;
                if (!err_q && !write_q) begin
                    resp_rdata = load_extend(split_q ? {mem_rdata, word0_q}
                                                     : {32'h0, mem_rdata},
                                             off_q, func3_q);
                end
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

endmodule

// File: doc/data_mem_master.md
DATA_MEM_MASTER -- requirements
Module: data_mem_master

Interface
REQ-001 SHALL have parameter ADDR_W, default 10, giving the memory word-index width (4 KiB of byte storage).
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state updates on posedge.
REQ-003 SHALL have port rst, input, 1 bit: asynchronous, active-low reset.
REQ-004 SHALL have port req_valid, input, 1 bit: MEM-stage access request.
REQ-005 SHALL have port req_ready, output, 1 bit: the request is accepted on the clk edge where req_valid and req_ready are both 1.
REQ-006 SHALL have port req_write, input, 1 bit: 1 = store, 0 = load.
REQ-007 SHALL have port req_func3, input, 3 bits: RISC-V size code (000 B, 001 H, 010 W, 100 BU, 101 HU).
REQ-008 SHALL have port req_addr, input, 32 bits: byte address.
REQ-009 SHALL have port req_wdata, input, 32 bits: store data, right-aligned.
REQ-010 SHALL have port resp_valid, output, 1 bit: one-cycle completion pulse.
REQ-011 SHALL have port resp_rdata, output, 32 bits: extended load data; 0 for stores and errors.
REQ-012 SHALL have port resp_err, output, 1 bit: illegal func3 or out-of-range access; valid with resp_valid.
REQ-013 SHALL have port mem_addr, output, ADDR_W bits: word index.
REQ-014 SHALL have port mem_re, output, 1 bit: word read strobe.
REQ-015 SHALL have port mem_we, output, 1 bit: word write strobe.
REQ-016 SHALL have port mem_be, output, 4 bits: byte-lane enables, bit i = byte i of the word.
REQ-017 SHALL have port mem_wdata, output, 32 bits: lane-aligned store data.
REQ-018 SHALL have port mem_rdata, input, 32 bits: read data, valid the cycle after mem_re.

Function
REQ-019 SHALL implement FSM states IDLE, ACC0, ACC1, DONE; req_ready = 1 only in IDLE.
REQ-020 SHALL latch all req_* fields on acceptance; offset o = req_addr[1:0]; word w = req_addr[ADDR_W+1:2].
REQ-021 SHALL classify as split when (H/HU and o = 3) or (W and o != 0).
REQ-022 SHALL flag an error when req_func3 is 011/110/111, when a store has func3[2] = 1, or when the last accessed byte exceeds 4*2^ADDR_W-1.
REQ-023 On an error, SHALL go IDLE -> DONE with no mem_re or mem_we asserted, resp_err = 1 and resp_rdata = 0.
REQ-024 In ACC0, SHALL drive mem_addr = w, mem_be = (size mask << o)[3:0], mem_wdata = req_wdata << 8*o, and assert exactly one of mem_re/mem_we for one cycle; next state is ACC1 if split, else DONE.
REQ-025 In ACC1, SHALL drive mem_addr = w+1, mem_be = size mask >> (4-o), mem_wdata = req_wdata >> 8*(4-o), and capture the word-0 read data; next state is DONE.
REQ-026 In DONE, SHALL capture the final read word, assert resp_valid for exactly one cycle, then return to IDLE.
REQ-027 SHALL form load data as ({word1, word0} >> 8*o) truncated to 8/16/32 bits; B/H sign-extended, BU/HU zero-extended.
REQ-028 Latency: acceptance at edge N gives resp_valid in cycle N+2 (non-split) or N+3 (split); error responses in cycle N+1.
REQ-029 SHALL hold mem_re, mem_we and mem_be at 0 outside ACC0/ACC1; store data SHALL never be driven with mem_we = 0.
REQ-030 SHALL ignore req_valid outside IDLE; no request is queued or lost, since the requester holds it until req_ready.

Reset
REQ-031 While rst = 0, SHALL force state IDLE and drive req_ready = 1 and resp_valid, resp_err, mem_re, mem_we, mem_be, resp_rdata, mem_addr, mem_wdata = 0.
REQ-032 Reset asserted mid-access SHALL abort immediately: no further strobes and no resp_valid for the aborted request.
REQ-033 After rst deasserts, the first accepted request SHALL behave identically to one accepted after power-up.

Verification
REQ-034 Word 0x20 = 0x123480F0, LB at 0x81 -> ACC0 mem_addr 0x20 be 0010 re; resp_rdata 0xFFFFFF80 at N+2; LBU gives 0x00000080.
REQ-035 SW 0x11223344 at 0x102 -> ACC0 addr 0x40 be 1100 wdata 0x33440000; ACC1 addr 0x41 be 0011 wdata 0x00001122; resp_valid at N+3, resp_rdata 0.
REQ-036 Words 0x40 = 0xAABBCCDD and 0x41 = 0x00000011, LH at 0x103 -> two reads; resp_rdata 0x000011AA.
REQ-037 func3 = 011 at addr 0, and separately LW at 0xFFE (ADDR_W = 10) -> no strobes; resp_err = 1 at N+1.
REQ-038 rst low during ACC1 of a split store -> mem_we drops the same cycle, no resp_valid; a following LW at 0x80 completes normally at N+2.
